alu_mul_sched: RTL and testbench

ALU_MUL_SCHED -- requirements
Module: alu_mul_sched

---
 rtl/alu_mul_sched.sv | 82 ++++++++
 tb/tb_alu_mul_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sched.sv
// Issue scheduler for a single-cycle ALU and a fixed-latency multiplier.
// Tracks the in-flight MUL and presents one result at a time downstream.
module alu_mul_sched #(
    parameter int MUL_LATENCY = 5,
    parameter int RD_WIDTH    = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_is_mul,
    input  logic [RD_WIDTH-1:0] req_rd,
    input  logic                dn_stall,
    output logic                req_ready,
    output logic                mul_start,
    output logic [3:0]          mul_count,
    output logic                res_valid,
    output logic                res_sel_mul,
    output logic [RD_WIDTH-1:0] res_rd,
    output logic                busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MUL_RUN = 2'd1;
    localparam logic [1:0] MUL_WB  = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(MUL_LATENCY - 1);
    localparam logic [3:0] FULL_CNT = 4'(MUL_LATENCY);

    logic [1:0]          state;
    logic [RD_WIDTH-1:0] rd_lat;
    logic                accept;

    assign req_ready = (state != MUL_RUN) & ~dn_stall;
    assign accept    = req_valid & req_ready;
    assign mul_start = accept & req_is_mul & reset;
    assign busy      = (state == MUL_RUN) | (state == MUL_WB);

    // A stall freezes every register; results and the counter only move when downstream takes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mul_count   <= 4'd0;
            res_valid   <= 1'b0;
            res_sel_mul <= 1'b0;
            res_rd      <= '0;
            rd_lat      <= '0;
        end else if (!dn_stall) begin
            unique case (state)
                MUL_RUN: begin
                    if (mul_count == LAST_CNT) begin
                        state       <= MUL_WB;
                        mul_count   <= FULL_CNT;
                        res_valid   <= 1'b1;
                        res_sel_mul <= 1'b1;
                        res_rd      <= rd_lat;
                    end else begin
                        mul_count <= mul_count + 4'd1;
                    end
                end
                default: begin
                    if (accept && req_is_mul) begin
                        state     <= MUL_RUN;
                        mul_count <= 4'd1;
                        res_valid <= 1'b0;
                        rd_lat    <= req_rd;
                    end else if (accept) begin
                        state       <= IDLE;
                        mul_count   <= 4'd0;
                        res_valid   <= 1'b1;
                        res_sel_mul <= 1'b0;
                        res_rd      <= req_rd;
                    end else begin
                        state     <= IDLE;
                        mul_count <= 4'd0;
                        res_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sched.sv
// Directed bench for alu_mul_sched with a result scoreboard.
// Expected results are queued at issue and checked when consumed.
module tb_alu_mul_sched;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_is_mul = 1'b0;
    logic [4:0] req_rd = '0;
    logic       dn_stall = 1'b0;
    logic       req_ready;
    logic       mul_start;
    logic [3:0] mul_count;
    logic       res_valid;
    logic       res_sel_mul;
    logic [4:0] res_rd;
    logic       busy;

    typedef struct {
        logic       sel;
        logic [4:0] rd;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    alu_mul_sched #(.MUL_LATENCY(5), .RD_WIDTH(5)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_is_mul(req_is_mul),
        .req_rd(req_rd),
        .dn_stall(dn_stall),
        .req_ready(req_ready),
        .mul_start(mul_start),
        .mul_count(mul_count),
        .res_valid(res_valid),
        .res_sel_mul(res_sel_mul),
        .res_rd(res_rd),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: check each consumed result against the queue
    always @(negedge clock) begin
        if (reset && res_valid && !dn_stall) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got rd %0d sel %0d expected none",
                         res_rd, res_sel_mul);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_sel", int'(res_sel_mul), int'(e.sel));
                chk("sb_rd", int'(res_rd), int'(e.rd));
                chk("sb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input logic v, input logic m,
                         input logic [4:0] rd, input logic st);
        req_valid  = v;
        req_is_mul = m;
        req_rd     = rd;
        dn_stall   = st;
        @(negedge clock);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_res(input logic sel, input logic [4:0] rd,
                              input int dly);
        exp_t e;
        e.sel = sel;
        e.rd  = rd;
        e.cyc = cyc + dly;
        exp_q.push_back(e);
    endtask

    initial begin
        int c0;
        // reset state, combinational outputs during reset
        drive(1'b1, 1'b1, 5'd9, 1'b0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_mul_count", int'(mul_count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_mul_start", int'(mul_start), 0);
        dn_stall = 1'b1;
        #1;
        chk("rst_req_ready_stall", int'(req_ready), 0);
        tick();
        reset = 1'b1;

        // ADD rd=3
        expect_res(1'b0, 5'd3, 1);
        drive(1'b1, 1'b0, 5'd3, 1'b0);
        chk("add_ready", int'(req_ready), 1);
        chk("add_mul_start", int'(mul_start), 0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        chk("add_valid_c1", int'(res_valid), 1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        chk("add_valid_c2", int'(res_valid), 0);
        tick();

        // MUL rd=7, ADD offers during run are ignored
        expect_res(1'b1, 5'd7, 5);
        drive(1'b1, 1'b1, 5'd7, 1'b0);
        chk("mul_start_c0", int'(mul_start), 1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 5'd9, 1'b0);
            chk("mul_run_ready", int'(req_ready), 0);
            chk("mul_run_count", int'(mul_count), i);
            chk("mul_run_start", int'(mul_start), 0);
            chk("mul_run_busy", int'(busy), 1);
            chk("mul_run_valid", int'(res_valid), 0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        chk("mul_wb_count", int'(mul_count), 5);
        chk("mul_wb_valid", int'(res_valid), 1);
        chk("mul_wb_rd", int'(res_rd), 7);
        chk("mul_wb_busy", int'(busy), 1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        chk("mul_done_valid", int'(res_valid), 0);
        chk("mul_done_busy", int'(busy), 0);
        chk("mul_done_count", int'(mul_count), 0);
        tick();

        // MUL with stall in cycles 2-3
        expect_res(1'b1, 5'd5, 7);
        drive(1'b1, 1'b1, 5'd5, 1'b0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b1);
            chk("run_stall_count", int'(mul_count), 2);
            tick();
        end
        for (int i = 2; i <= 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b0);
            chk("run_resume_count", int'(mul_count), i);
            chk("run_resume_valid", int'(res_valid), 0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        chk("run_stall_valid_c7", int'(res_valid), 1);
        tick();

        // MUL result held under a 3-cycle WB stall
        expect_res(1'b1, 5'd6, 8);
        drive(1'b1, 1'b1, 5'd6, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 5'd11, 1'b1);
            chk("wb_stall_valid", int'(res_valid), 1);
            chk("wb_stall_rd", int'(res_rd), 6);
            chk("wb_stall_count", int'(mul_count), 5);
            chk("wb_stall_ready", int'(req_ready), 0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        chk("wb_release_valid", int'(res_valid), 1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        chk("wb_after_valid", int'(res_valid), 0);
        tick();

        // MUL rd=2 then ADD rd=4 in WB, MUL rd=8, then MUL rd=1 in WB
        expect_res(1'b1, 5'd2, 5);
        drive(1'b1, 1'b1, 5'd2, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b0);
            tick();
        end
        expect_res(1'b0, 5'd4, 1);
        drive(1'b1, 1'b0, 5'd4, 1'b0);
        chk("b2b_wb_ready", int'(req_ready), 1);
        chk("b2b_wb_valid", int'(res_valid), 1);
        tick();
        expect_res(1'b1, 5'd8, 5);
        drive(1'b1, 1'b1, 5'd8, 1'b0);
        chk("b2b_add_valid", int'(res_valid), 1);
        chk("b2b_add_sel", int'(res_sel_mul), 0);
        chk("b2b_add_rd", int'(res_rd), 4);
        chk("b2b_mul_start", int'(mul_start), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b0);
            tick();
        end
        expect_res(1'b1, 5'd1, 5);
        drive(1'b1, 1'b1, 5'd1, 1'b0);
        chk("b2b_wb_mul_start", int'(mul_start), 1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        chk("b2b_mul2_count", int'(mul_count), 1);
        chk("b2b_mul2_valid", int'(res_valid), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b0);
            tick();
        end

        // ADD held one cycle by a stall
        expect_res(1'b0, 5'd10, 2);
        drive(1'b1, 1'b0, 5'd10, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd13, 1'b1);
        chk("add_stall_valid", int'(res_valid), 1);
        chk("add_stall_rd", int'(res_rd), 10);
        chk("add_stall_start", int'(mul_start), 0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0);
        tick();

        // reset in cycle 3 of a MUL discards it
        drive(1'b1, 1'b1, 5'd12, 1'b0);
        tick();
        c0 = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b0);
            tick();
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", int'(res_valid), 0);
        chk("mid_rst_count", int'(mul_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b1;
        expect_res(1'b0, 5'd15, 1);
        drive(1'b1, 1'b0, 5'd15, 1'b0);
        chk("post_rst_ready", int'(req_ready), 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b0);
            if (res_valid) c0++;
            tick();
        end
        chk("post_rst_offers", c0, 1);
        chk("sb_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
